// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM DAC/decoder pair: window length, decoder
// state encoding and a small majority helper.
package pwm_pkg;

    // Window length used by both the transmitting DAC and the decoder.
    localparam int PWM_CYCLES_PER_WINDOW = 1024;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } pwm_dec_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser with synchronous active-high reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pwm_decoder.sv
// Recovers the code from a windowed PWM stream; aligns on rising edges.
// Optional 3-sample glitch filter: define PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CYCLES_PER_WINDOW = PWM_CYCLES_PER_WINDOW,
    parameter int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW),
    parameter int SYNC_STAGES       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_in,
    output logic [CODE_WIDTH-1:0] code,
    output logic                  code_valid,
    output logic                  locked,
    output logic                  resync
);

    localparam logic [CODE_WIDTH-1:0] LAST_IDX = CODE_WIDTH'(CYCLES_PER_WINDOW - 1);
    localparam logic [CODE_WIDTH:0]   FULL_CNT = (CODE_WIDTH + 1)'(CYCLES_PER_WINDOW);
    localparam logic [CODE_WIDTH:0]   ONE_CNT  = (CODE_WIDTH + 1)'(1);
    localparam logic [CODE_WIDTH-1:0] ONE_IDX  = CODE_WIDTH'(1);

    logic sync_out;
    logic s;
    logic s_prev;
    logic rise;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pwm_in),
        .q   (sync_out)
    );

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    // Centred majority over the last three synchronised samples: one cycle of
    // delay, and any isolated single-sample pulse or dropout disappears.
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
        end else begin
            hist <= {hist[0], sync_out};
        end
    end

    assign s = maj3(sync_out, hist[0], hist[1]);
`else
    assign s = sync_out;
`endif

    assign rise = s & ~s_prev;

    pwm_dec_state_t          state, state_d;
    logic [CODE_WIDTH-1:0]   idx, idx_d;
    logic [CODE_WIDTH:0]     hcnt, hcnt_d;
    logic [CODE_WIDTH:0]     h_final;
    logic [CODE_WIDTH-1:0]   code_next;
    logic                    emit;
    logic                    resync_d;
    logic                    last;

    // Count including the sample being processed this cycle.
    assign h_final   = hcnt + (CODE_WIDTH + 1)'(s);
    assign code_next = (h_final == '0) ? '0 : CODE_WIDTH'(h_final - ONE_CNT);
    assign last      = (idx == LAST_IDX);

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        idx_d    = idx + ONE_IDX;
        hcnt_d   = h_final;
        emit     = 1'b0;
        resync_d = 1'b0;

        case (state)
            HUNT: begin
                if (rise) begin
                    // The edge sample is index 0 of the first aligned window.
                    state_d = LOCK;
                    idx_d   = ONE_IDX;
                    hcnt_d  = ONE_CNT;
                end else if (last) begin
                    idx_d  = '0;
                    hcnt_d = '0;
                    emit   = (h_final == '0) || (h_final == FULL_CNT);
                end
            end
            LOCK: begin
                if (rise && (idx != '0)) begin
                    idx_d    = ONE_IDX;
                    hcnt_d   = ONE_CNT;
                    resync_d = 1'b1;
                end else if (last) begin
                    idx_d  = '0;
                    hcnt_d = '0;
                    emit   = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            idx        <= '0;
            hcnt       <= '0;
            s_prev     <= 1'b0;
            code       <= '0;
            code_valid <= 1'b0;
            resync     <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            hcnt       <= hcnt_d;
            s_prev     <= s;
            code_valid <= emit;
            resync     <= resync_d;
            if (emit) begin
                code <= code_next;
            end
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: table of steady DAC codes plus hand-built
// sequences for code switching, injected pulses and mid-window reset.
module tb_pwm_decoder;
    import pwm_pkg::*;

    localparam int N    = PWM_CYCLES_PER_WINDOW;
    localparam int CW   = $clog2(N);
    localparam int SYNC = 2;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int LAT        = SYNC + 1;
    localparam int PULSE_LEN  = 1;
    localparam int EXP_RESYNC = 0;
    localparam int EXP_B_CNT  = 5;
`else
    localparam int LAT        = SYNC;
    localparam int PULSE_LEN  = 3;
    // The injected edge realigns mid-window, and the DAC's next real edge then
    // lands at a non-zero index of the realigned window, realigning once more.
    localparam int EXP_RESYNC = 2;
    localparam int EXP_B_CNT  = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] code;
    logic          code_valid;
    logic          locked;
    logic          resync;

    pwm_decoder #(
        .CYCLES_PER_WINDOW (N),
        .SYNC_STAGES       (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .code       (code),
        .code_valid (code_valid),
        .locked     (locked),
        .resync     (resync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Output monitor, sampling on the falling edge.
    int cyc = 0;
    int got_codes[$];
    int got_stamps[$];
    int n_resync = 0;
    int n_both   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (code_valid) begin
                got_codes.push_back(int'(code));
                got_stamps.push_back(cyc);
            end
            if (resync) n_resync++;
            if (code_valid && resync) n_both++;
        end
    end

    task automatic drive_cycle(input logic v, input logic r);
        @(posedge clk);
        #1;
        pwm_in = v;
        rst    = r;
    endtask

    // DAC model: high for indices 0..c when c is non-zero.
    function automatic logic dac_bit(input int c, input int i);
        return (c != 0) && (i <= c);
    endfunction

    task automatic do_reset();
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b1);
        got_codes.delete();
        got_stamps.delete();
        n_resync = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " code"}, int'(code), 0);
        check({tag, " code_valid"}, int'(code_valid), 0);
        check({tag, " locked"}, int'(locked), 0);
        check({tag, " resync"}, int'(resync), 0);
    endtask

    typedef struct {
        int dac_code;
        int exp_code;
        int exp_locked;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{dac_code: 512,  exp_code: 512,  exp_locked: 1};
        vecs[1] = '{dac_code: 0,    exp_code: 0,    exp_locked: 0};
        vecs[2] = '{dac_code: 1023, exp_code: 1023, exp_locked: 1};
        vecs[3] = '{dac_code: 1,    exp_code: 1,    exp_locked: 1};
        vecs[4] = '{dac_code: 700,  exp_code: 700,  exp_locked: 1};

        do_reset();
        check_outputs_zero("reset");

        // Steady codes: three windows each, checking lock timing, codes and period.
        foreach (vecs[v]) begin
            do_reset();
            for (int i = 0; i < 3 * N + 8; i++) begin
                drive_cycle(dac_bit(vecs[v].dac_code, i % N), 1'b0);
                if (i == LAT)     check($sformatf("v%0d locked pre-edge", v), int'(locked), 0);
                if (i == LAT + 1) check($sformatf("v%0d locked post-edge", v), int'(locked), vecs[v].exp_locked);
            end
            check($sformatf("v%0d valid count", v), got_codes.size(), 3);
            foreach (got_codes[k]) begin
                check($sformatf("v%0d code[%0d]", v, k), got_codes[k], vecs[v].exp_code);
                if (k > 0) check($sformatf("v%0d period[%0d]", v, k), got_stamps[k] - got_stamps[k-1], N);
            end
            check($sformatf("v%0d resync count", v), n_resync, 0);
            check($sformatf("v%0d locked end", v), int'(locked), vecs[v].exp_locked);
        end

        // Code 1 for two windows, then 700 from a window boundary.
        begin
            int exp_a[4] = '{1, 1, 700, 700};
            do_reset();
            for (int i = 0; i < 4 * N + 8; i++) begin
                drive_cycle(dac_bit((i < 2 * N) ? 1 : 700, i % N), 1'b0);
            end
            check("switch valid count", got_codes.size(), 4);
            foreach (got_codes[k]) begin
                if (k < 4) check($sformatf("switch code[%0d]", k), got_codes[k], exp_a[k]);
            end
            check("switch resync count", n_resync, 0);
        end

        // Code 300 with an extra pulse at index 600 of the third window.
        begin
            do_reset();
            for (int i = 0; i < 5 * N + 8; i++) begin
                drive_cycle(dac_bit(300, i % N) |
                            ((i >= 2 * N + 600) && (i < 2 * N + 600 + PULSE_LEN)), 1'b0);
            end
            check("pulse valid count", got_codes.size(), EXP_B_CNT);
            foreach (got_codes[k]) check($sformatf("pulse code[%0d]", k), got_codes[k], 300);
            check("pulse resync count", n_resync, EXP_RESYNC);
            check("pulse locked end", int'(locked), 1);
        end

        // One-cycle reset at index 500 of the second window while locked at 100.
        begin
            do_reset();
            for (int i = 0; i < 4 * N + 8; i++) begin
                drive_cycle(dac_bit(100, i % N), i == N + 500);
                if (i == N + 499) begin
                    check("rst locked before", int'(locked), 1);
                    check("rst code before", int'(code), 100);
                end
                if (i == N + 501) check_outputs_zero("mid-window rst");
                if (i == 2 * N)   check("rst still hunting", int'(locked), 0);
            end
            check("rst valid count", got_codes.size(), 3);
            foreach (got_codes[k]) check($sformatf("rst code[%0d]", k), got_codes[k], 100);
            if (got_stamps.size() == 3) check("rst relock period", got_stamps[2] - got_stamps[1], N);
            check("rst resync count", n_resync, 0);
            check("rst locked end", int'(locked), 1);
        end

        check("valid/resync overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
